result_digit_feeder: RTL

- Sequential front end that produces the 12 hex/BCD nibbles and the bank-select line consumed by the six-digit dual-bank seven-segment selector.
- Accepts one result word plus a 24-bit tag (matrix element index/address) over a valid/ready handshake.
- Converts the result to 6 decimal BCD digits (bank a) by iterative double-dabble; passes the tag as 6 hex nibbles (bank b).
- Alternates the displayed bank on a programmable period.

---
 rtl/result_digit_feeder_if.sv | 18 +
 rtl/result_digit_feeder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/result_digit_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : result_digit_feeder_if
// Brief  : Result/tag valid-ready handshake into the digit feeder.
// Rev    : 1.0
// ============================================================================
interface result_digit_feeder_if #(
    parameter int DATA_W = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_value;
    logic [23:0]       in_tag;

    modport master (output in_valid, output in_value, output in_tag, input in_ready);
    modport slave  (input in_valid, input in_value, input in_tag, output in_ready);
endinterface
`default_nettype wire

// File: rtl/result_digit_feeder.sv
`default_nettype none
// ============================================================================
// Module : result_digit_feeder
// Brief  : Double-dabble BCD result (bank a), hex tag (bank b), timed bank select.
// Rev    : 1.0
// ============================================================================
module result_digit_feeder #(
    parameter int DATA_W        = 20,
    parameter int TOGGLE_CYCLES = 50000000
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    result_digit_feeder_if.slave      in_if,
    input  wire logic                 hold,
    output logic                      select,
    output logic [3:0]                HEX0a, HEX1a, HEX2a, HEX3a, HEX4a, HEX5a,
    output logic [3:0]                HEX0b, HEX1b, HEX2b, HEX3b, HEX4b, HEX5b,
    output logic                      ovf,
    output logic                      update
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TOGGLE_CYCLES);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_CONVERT = 2'd1;
    localparam logic [1:0] C_COMMIT  = 2'd2;

    localparam logic [TW-1:0] C_TLAST = TW'(TOGGLE_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [23:0]       bcd_q, bcd_d;
    logic [23:0]       tag_q, tag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              big_q, big_d;
    logic [23:0]       hex_a_q, hex_a_d;
    logic [23:0]       hex_b_q, hex_b_d;
    logic              ovf_q, ovf_d;
    logic              update_q, update_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              select_q, select_d;
    logic [23:0]       w_bcd_adj;
    logic              w_too_big;

    // Add-3 correction is per nibble; no carry crosses nibble boundaries.
    for (genvar i = 0; i < 6; i++) begin : g_nib
        assign w_bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                               : bcd_q[4*i +: 4];
    end

    assign w_too_big      = (64'(in_if.in_value) > 64'd999999);
    assign in_if.in_ready = (state_q == C_IDLE);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        big_d    = big_q;
        hex_a_d  = hex_a_q;
        hex_b_d  = hex_b_q;
        ovf_d    = ovf_q;
        update_d = 1'b0;
        timer_d  = timer_q;
        select_d = select_q;

        case (state_q)
            C_IDLE: begin
                if (in_if.in_valid) begin
                    shift_d = in_if.in_value;
                    tag_d   = in_if.in_tag;
                    big_d   = w_too_big;
                    bcd_d   = 24'h0;
                    cnt_d   = CW'(DATA_W);
                    state_d = C_CONVERT;
                end
            end
            C_CONVERT: begin
                bcd_d   = {w_bcd_adj[22:0], shift_q[DATA_W-1]};
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = C_COMMIT;
                end
            end
            C_COMMIT: begin
                hex_a_d  = big_q ? 24'hEEEEEE : bcd_q;
                hex_b_d  = tag_q;
                ovf_d    = big_q;
                update_d = 1'b1;
                state_d  = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase

        // A commit restarts the display on bank a regardless of hold or a pending wrap.
        if (state_q == C_COMMIT) begin
            timer_d  = '0;
            select_d = 1'b0;
        end else if (!hold) begin
            if (timer_q == C_TLAST) begin
                timer_d  = '0;
                select_d = ~select_q;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= C_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            big_q    <= 1'b0;
            hex_a_q  <= '0;
            hex_b_q  <= '0;
            ovf_q    <= 1'b0;
            update_q <= 1'b0;
            timer_q  <= '0;
            select_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            big_q    <= big_d;
            hex_a_q  <= hex_a_d;
            hex_b_q  <= hex_b_d;
            ovf_q    <= ovf_d;
            update_q <= update_d;
            timer_q  <= timer_d;
            select_q <= select_d;
        end
    end

    assign {HEX5a, HEX4a, HEX3a, HEX2a, HEX1a, HEX0a} = hex_a_q;
    assign {HEX5b, HEX4b, HEX3b, HEX2b, HEX1b, HEX0b} = hex_b_q;
    assign ovf    = ovf_q;
    assign update = update_q;
    assign select = select_q;

endmodule
`default_nettype wire
